fpu_addsub_issue_ctrl: RTL and testbench
========================================

Name: fpu_addsub_issue_ctrl

Overview:
- Handshake front-end and result-capture stage that sits directly upstream and downstream of the add/subtract core.
- Accepts an operation over a valid/ready interface and latches the operands, add_subt and r_mode.
- Pulses beg_FSM, waits for the core's ready, then captures final_result_ieee and the overflow/underflow flags, and pulses rst_FSM to return the core to idle.
- Presents the result on a valid/ready output with backpressure; a watchdog aborts a hung core.

Parameters:
W, 64, operand/result width (32 for single precision)
TIMEOUT_CYC, 256, maximum cycles allowed in WAIT before abort (>=4)
CNT_W, 9, width of the watchdog counter (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_x  in  W  operand X
in_y  in  W  operand Y
in_add_subt  in  1  0=add, 1=subtract
in_r_mode  in  2  rounding mode
core_beg_FSM  out  1  start pulse to core
core_rst_FSM  out  1  return-to-idle pulse to core
core_Data_X  out  W  latched operand X
core_Data_Y  out  W  latched operand Y
core_add_subt  out  1  latched op
core_r_mode  out  2  latched rounding mode
core_ready  in  1  core done (level, held until rst_FSM)
core_result  in  W  core final_result_ieee
core_overflow  in  1  core overflow_flag
core_underflow  in  1  core underflow_flag
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_result  out  W  captured result
out_overflow  out  1  captured overflow
out_underflow  out  1  captured underflow
out_timeout  out  1  1 = aborted by watchdog; result forced to 0

Behaviour:
- Reset (async): state=IDLE. All outputs 0 except in_ready=1. Operand, result and counter registers cleared. No pulse is emitted on reset release.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_x/in_y/in_add_subt/in_r_mode into the core_* registers, then go to LAUNCH.
  - Latched operands are held stable until the state returns to IDLE.
- LAUNCH:
  - core_beg_FSM=1 for exactly one cycle; watchdog cleared to 0.
  - If core_ready is already 1 here (stale core), do not pulse beg. Go to RELEASE with out_timeout=1 and result=0.
  - Otherwise go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If core_ready=1: capture core_result, core_overflow, core_underflow and set out_timeout=0, then go to RELEASE.
  - Else if counter==TIMEOUT_CYC-1: capture result=0, flags=0, out_timeout=1, then go to RELEASE.
  - If core_ready and timeout coincide, core_ready wins.
- RELEASE:
  - core_rst_FSM=1 on the first cycle only.
  - Stay until core_ready==0, then go to DONE. Sampling core_ready during the rst_FSM cycle itself is ignored.
- DONE:
  - out_valid=1; out_* held stable while out_ready=0.
  - On out_valid&&out_ready go to IDLE; in_ready rises the next cycle (no same-cycle bypass).
- in_ready=0 in every state except IDLE. One operation in flight maximum.
- Latency:
  - Acceptance at cycle 0; beg at cycle 1.
  - With core_ready first seen at cycle k: rst_FSM at k+1.
  - out_valid at earliest k+3 (core_ready drops at k+2).
- core_beg_FSM and core_rst_FSM are registered outputs, never asserted together.
- Reset mid-operation: everything returns to IDLE at once, with no rst_FSM pulse. The core shares rst, so both are consistent.
- Counter saturates and never wraps.

Decomposition:
- Shared package fpu_addsub_pkg holds:
  - state enum IDLE/LAUNCH/WAIT/RELEASE/DONE (3-bit encoding 0..4);
  - TIMEOUT_CYC default;
  - W defaults for single and double precision.
- One sub-module: fpu_watchdog_cnt. It is a clearable, saturating up-counter with a terminal-count compare output.

Test Plan:
- Double add:
  - Stimulus: in_x=0x3FF0000000000000, in_y=0x4000000000000000, add_subt=0; core model asserts ready 20 cycles after beg.
  - Required: out_result=0x4008000000000000, flags 0, out_timeout=0; beg at cycle 1, rst_FSM at cycle 22, out_valid at cycle 24.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE; drive in_valid=1 throughout.
  - Required: out_* stable, in_ready=0, no second beg; after the handshake, in_ready=1 on the next cycle.
- Overflow:
  - Stimulus: core returns result 0x7FF0000000000000 with overflow=1.
  - Required: out_overflow=1, out_result=0x7FF0000000000000, out_underflow=0.
- Timeout:
  - Stimulus: core never asserts ready, TIMEOUT_CYC=16.
  - Required: rst_FSM at cycle 18, out_timeout=1, out_result=0.
- Reset mid-WAIT:
  - Stimulus: assert rst at cycle 5.
  - Required: immediate in_ready=1, out_valid=0, no beg/rst_FSM pulses; a new request after reset completes normally.
- Stale core:
  - Stimulus: core_ready=1 at acceptance.
  - Required: no beg pulse, rst_FSM pulse issued, out_timeout=1.

Source files
------------

// File: rtl/fpu_addsub_pkg.sv
`default_nettype none
// ============================================================================
// fpu_addsub_pkg : state encoding and size defaults for the add/sub issue ctrl
// Rev 1.0
// ============================================================================
package fpu_addsub_pkg;

  localparam int W_SP            = 32;
  localparam int W_DP            = 64;
  localparam int TIMEOUT_CYC_DEF = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fpu_watchdog_cnt.sv
`default_nettype none
// ============================================================================
// fpu_watchdog_cnt : clearable saturating up-counter with terminal-count flag
// Rev 1.0
// ============================================================================
module fpu_watchdog_cnt #(
  parameter int CNT_W  = 9,
  parameter int TC_VAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] c_tc_val = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == c_tc_val);

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
// fpu_addsub_issue_ctrl : valid/ready front-end and result capture around the
//                         add/subtract core, with a watchdog abort.
// Rev 1.0
// ============================================================================
module fpu_addsub_issue_ctrl
  import fpu_addsub_pkg::*;
#(
  parameter int W           = W_DP,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic         in_add_subt,
  input  logic [1:0]   in_r_mode,
  output logic         core_beg_FSM,
  output logic         core_rst_FSM,
  output logic [W-1:0] core_Data_X,
  output logic [W-1:0] core_Data_Y,
  output logic         core_add_subt,
  output logic [1:0]   core_r_mode,
  input  logic         core_ready,
  input  logic [W-1:0] core_result,
  input  logic         core_overflow,
  input  logic         core_underflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_overflow,
  output logic         out_underflow,
  output logic         out_timeout
);

  state_e         state_q, state_d;
  logic           beg_q, beg_d, rstf_q, rstf_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d, res_q, res_d;
  logic           op_q, op_d, ov_q, ov_d, un_q, un_d, to_q, to_d;
  logic [1:0]     rm_q, rm_d;
  logic           wd_tc;

  fpu_watchdog_cnt #(
    .CNT_W  (CNT_W),
    .TC_VAL (TIMEOUT_CYC - 1)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == LAUNCH),
    .inc_i (state_q == WAIT),
    .tc_o  (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    beg_d   = 1'b0;
    rstf_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    rm_d    = rm_q;
    res_d   = res_q;
    ov_d    = ov_q;
    un_d    = un_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          op_d    = in_add_subt;
          rm_d    = in_r_mode;
          // a core already reporting ready is stale: skip the start pulse
          beg_d   = !core_ready;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (core_ready) begin
          res_d   = '0;
          ov_d    = 1'b0;
          un_d    = 1'b0;
          to_d    = 1'b1;
          rstf_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (core_ready) begin
          res_d   = core_result;
          ov_d    = core_overflow;
          un_d    = core_underflow;
          to_d    = 1'b0;
          rstf_d  = 1'b1;
          state_d = RELEASE;
        end else if (wd_tc) begin
          res_d   = '0;
          ov_d    = 1'b0;
          un_d    = 1'b0;
          to_d    = 1'b1;
          rstf_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // core_ready is still the old level while rst_FSM is being driven
        if (!rstf_q && !core_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beg_q   <= 1'b0;
      rstf_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= 1'b0;
      rm_q    <= 2'b00;
      res_q   <= '0;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beg_q   <= beg_d;
      rstf_q  <= rstf_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
      to_q    <= to_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign core_beg_FSM  = beg_q;
  assign core_rst_FSM  = rstf_q;
  assign core_Data_X   = x_q;
  assign core_Data_Y   = y_q;
  assign core_add_subt = op_q;
  assign core_r_mode   = rm_q;
  assign out_result    = res_q;
  assign out_overflow  = ov_q;
  assign out_underflow = un_q;
  assign out_timeout   = to_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fpu_addsub_issue_ctrl : per-operation timeline model with random traffic
// Rev 1.0
// ============================================================================
module tb_fpu_addsub_issue_ctrl;

  localparam int W      = 64;
  localparam int T      = 32;
  localparam int CW     = 6;
  localparam int NOPS   = 40;
  localparam int MAXCYC = 20000;

  // lat: -1 stale core, 0 core never answers, >0 cycles from beg to core_ready
  typedef struct {
    int          lat;
    logic [63:0] x, y, res;
    logic        op, ov, un;
    logic [1:0]  rm;
    int          hold;
    int          rst_at;
    bit          ivh;
    int          pin;
  } op_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_add_subt = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0;
  logic [1:0]   in_r_mode = 2'b00;
  logic         core_ready = 1'b0, core_overflow = 1'b0, core_underflow = 1'b0;
  logic [W-1:0] core_result = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, core_beg_FSM, core_rst_FSM, core_add_subt;
  logic [W-1:0] core_Data_X, core_Data_Y, out_result;
  logic [1:0]   core_r_mode;
  logic         out_valid, out_overflow, out_underflow, out_timeout;

  always #5 clk = ~clk;

  fpu_addsub_issue_ctrl #(
    .W           (W),
    .TIMEOUT_CYC (T),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_x           (in_x),
    .in_y           (in_y),
    .in_add_subt    (in_add_subt),
    .in_r_mode      (in_r_mode),
    .core_beg_FSM   (core_beg_FSM),
    .core_rst_FSM   (core_rst_FSM),
    .core_Data_X    (core_Data_X),
    .core_Data_Y    (core_Data_Y),
    .core_add_subt  (core_add_subt),
    .core_r_mode    (core_r_mode),
    .core_ready     (core_ready),
    .core_result    (core_result),
    .core_overflow  (core_overflow),
    .core_underflow (core_underflow),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_overflow   (out_overflow),
    .out_underflow  (out_underflow),
    .out_timeout    (out_timeout)
  );

  // model state (written by the stimulus process only)
  op_t         ops[NOPS];
  op_t         cur;
  int          cyc = -2, opi = 0;
  int          a_cyc = 0, beg_cyc = -100, rst_cyc = -100, val_cyc = 1 << 30;
  int          cap_cyc = -100, rdy_from = 1 << 30, rdy_to = -1;
  bit          busy = 1'b0, rst_now = 1'b1, hung = 1'b0;
  logic [63:0] e_res = '0;
  logic        e_ov = 1'b0, e_un = 1'b0, e_to = 1'b0;

  // compare-process state
  int          n_chk = 0, n_pass = 0;
  int          last_beg = -1000, last_rst = -1000, val_first = -1000;
  logic [63:0] res_first = '0;
  logic        ov_first = 1'b0, un_first = 1'b0, to_first = 1'b0, prev_valid = 1'b0;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%h, expected 0x%h", nm, cyc, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b, expected %b", nm, cyc, act, exp);
  endtask

  // hand-computed expectations for the directed operations
  task automatic pin_checks();
    case (cur.pin)
      1: begin
        chkw("add_beg_cycle", 64'(last_beg - a_cyc), 64'(1));
        chkw("add_rstFSM_cycle", 64'(last_rst - a_cyc), 64'(22));
        chkw("add_valid_cycle", 64'(val_first - a_cyc), 64'(24));
        chkw("add_result", res_first, 64'h4008000000000000);
        chkw("add_flags", 64'({ov_first, un_first, to_first}), 64'(0));
      end
      2: begin
        chkw("timeout_rstFSM_cycle", 64'(last_rst - a_cyc), 64'(T + 2));
        chk1("timeout_flag", to_first, 1'b1);
        chkw("timeout_result", res_first, 64'h0);
      end
      3: begin
        chk1("stale_no_beg", last_beg < a_cyc, 1'b1);
        chkw("stale_rstFSM_cycle", 64'(last_rst - a_cyc), 64'(2));
        chk1("stale_timeout", to_first, 1'b1);
      end
      4: begin
        chkw("ovf_result", res_first, 64'h7FF0000000000000);
        chk1("ovf_overflow", ov_first, 1'b1);
        chk1("ovf_underflow", un_first, 1'b0);
      end
      5: chkw("bp_hold_cycles", 64'(cyc - val_first), 64'(10));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (core_beg_FSM) last_beg = cyc;
    if (core_rst_FSM) last_rst = cyc;
    if (out_valid && !prev_valid) begin
      val_first = cyc;
      res_first = out_result;
      ov_first  = out_overflow;
      un_first  = out_underflow;
      to_first  = out_timeout;
    end
    prev_valid = out_valid;

    chk1("in_ready", in_ready, !(busy && cyc > a_cyc));
    chk1("beg_FSM", core_beg_FSM, busy && cyc == beg_cyc);
    chk1("rst_FSM", core_rst_FSM, busy && cyc == rst_cyc);
    chk1("out_valid", out_valid, busy && cyc >= val_cyc);
    if (busy && cyc > a_cyc) begin
      chkw("core_Data_X", core_Data_X, cur.x);
      chkw("core_Data_Y", core_Data_Y, cur.y);
      chk1("core_add_subt", core_add_subt, cur.op);
      chkw("core_r_mode", 64'(core_r_mode), 64'(cur.rm));
    end
    if (busy && cyc >= val_cyc) begin
      chkw("out_result", out_result, e_res);
      chk1("out_overflow", out_overflow, e_ov);
      chk1("out_underflow", out_underflow, e_un);
      chk1("out_timeout", out_timeout, e_to);
    end
    if (rst_now) begin
      chkw("rst_Data_X", core_Data_X, 64'h0);
      chkw("rst_Data_Y", core_Data_Y, 64'h0);
      chkw("rst_out_result", out_result, 64'h0);
      chkw("rst_out_flags", 64'({out_overflow, out_underflow, out_timeout, core_add_subt}), 64'(0));
    end
    if (busy && cyc >= val_cyc && out_ready) pin_checks();
    if (hung) begin
      n_chk++;
      $display("FAIL op_completion: got %0d ops done, expected %0d", opi, NOPS);
    end
  end

  task automatic plan();
    a_cyc = cyc;
    if (cur.lat < 0) begin
      beg_cyc = -100; rst_cyc = a_cyc + 2; rdy_from = a_cyc; rdy_to = a_cyc + 2;
      cap_cyc = -100; e_res = '0; e_ov = 1'b0; e_un = 1'b0; e_to = 1'b1;
    end else if (cur.lat == 0) begin
      beg_cyc = a_cyc + 1; rst_cyc = a_cyc + T + 2; rdy_from = 1 << 30; rdy_to = -1;
      cap_cyc = -100; e_res = '0; e_ov = 1'b0; e_un = 1'b0; e_to = 1'b1;
    end else begin
      beg_cyc = a_cyc + 1; cap_cyc = a_cyc + 1 + cur.lat; rst_cyc = cap_cyc + 1;
      rdy_from = cap_cyc; rdy_to = cap_cyc + 1;
      e_res = cur.res; e_ov = cur.ov; e_un = cur.un; e_to = 1'b0;
    end
    val_cyc = rst_cyc + 2;
  endtask

  task automatic drive_inputs();
    in_valid    = 1'b0;
    in_x        = rnd64();
    in_y        = rnd64();
    in_add_subt = 1'($urandom_range(0, 1));
    in_r_mode   = 2'($urandom_range(0, 3));
    if (!busy && !rst && opi < NOPS && $urandom_range(0, 3) != 0) begin
      cur = ops[opi];
      plan();
      busy = 1'b1;
      in_valid = 1'b1; in_x = cur.x; in_y = cur.y; in_add_subt = cur.op; in_r_mode = cur.rm;
    end else if (busy) begin
      in_valid = cur.ivh ? 1'b1 : 1'($urandom_range(0, 1));
    end
    core_ready     = busy && cyc >= rdy_from && cyc <= rdy_to;
    core_result    = (busy && cyc == cap_cyc) ? cur.res : rnd64();
    core_overflow  = (busy && cyc == cap_cyc) ? cur.ov : 1'($urandom_range(0, 1));
    core_underflow = (busy && cyc == cap_cyc) ? cur.un : 1'($urandom_range(0, 1));
    out_ready      = (busy && cyc >= val_cyc) ? (cyc - val_cyc >= cur.hold)
                                              : 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int i = 0; i < NOPS; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      ops[i].lat    = (r == 0) ? -1 : (r == 1) ? 0 : int'($urandom_range(1, T));
      ops[i].x      = rnd64();
      ops[i].y      = rnd64();
      ops[i].res    = rnd64();
      ops[i].op     = 1'($urandom_range(0, 1));
      ops[i].ov     = 1'($urandom_range(0, 1));
      ops[i].un     = 1'($urandom_range(0, 1));
      ops[i].rm     = 2'($urandom_range(0, 3));
      ops[i].hold   = int'($urandom_range(0, 3));
      ops[i].rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : 0;
      ops[i].ivh    = 1'b0;
      ops[i].pin    = 0;
    end
    ops[0].lat = 20; ops[0].x = 64'h3FF0000000000000; ops[0].y = 64'h4000000000000000;
    ops[0].op = 1'b0; ops[0].res = 64'h4008000000000000; ops[0].ov = 1'b0; ops[0].un = 1'b0;
    ops[0].hold = 0; ops[0].rst_at = 0; ops[0].pin = 1;
    ops[1].lat = 3; ops[1].hold = 10; ops[1].ivh = 1'b1; ops[1].rst_at = 0; ops[1].pin = 5;
    ops[2].lat = 5; ops[2].res = 64'h7FF0000000000000; ops[2].ov = 1'b1; ops[2].un = 1'b0;
    ops[2].rst_at = 0; ops[2].pin = 4;
    ops[3].lat = 0; ops[3].rst_at = 0; ops[3].pin = 2;
    ops[4].lat = 20; ops[4].rst_at = 5;
    ops[5].lat = 4; ops[5].rst_at = 0;
    ops[6].lat = -1; ops[6].rst_at = 0; ops[6].pin = 3;
    ops[7].lat = 1; ops[7].rst_at = 0;
    ops[8].lat = T; ops[8].rst_at = 0;

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; rst_now = 1'b0; cyc = 0;
    for (int it = 0; it < MAXCYC && opi < NOPS; it++) begin
      @(posedge clk);
      #1;
      if (busy && cyc >= val_cyc && out_ready) begin
        busy = 1'b0;
        opi++;
      end
      cyc++;
      rst_now = 1'b0;
      if (rst) rst = 1'b0;
      if (busy && cur.rst_at > 0 && cyc == a_cyc + cur.rst_at) begin
        rst = 1'b1; rst_now = 1'b1; busy = 1'b0;
        opi++;
      end
      drive_inputs();
    end
    if (opi < NOPS) hung = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
